dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl_pkg.sv | 20 ++
 rtl/dmem_lane_align.sv | 50 +++++
 rtl/dmem_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller.
// States, RISC-V load/store funct3 encodings and the statistics counter width.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int STAT_W = 16;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables and write shifting,
// load shifting with sign/zero extension, and access-size alignment check.
module dmem_lane_align
    import dmem_ctrl_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [4:0]  shamt;
    logic [31:0] rshift;

    assign shamt  = {addr_lo_i, 3'b000};
    assign rshift = rword_i >> shamt;

    always_comb begin
        be_o       = 4'b0000;
        wword_o    = wdata_i << shamt;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        case (funct3_i)
            F3_B, F3_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                rdata_o = (funct3_i == F3_B) ? {{24{rshift[7]}}, rshift[7:0]}
                                             : {24'h0, rshift[7:0]};
            end
            F3_H, F3_HU: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misalign_o = addr_lo_i[0];
                rdata_o    = (funct3_i == F3_H) ? {{16{rshift[15]}}, rshift[15:0]}
                                                : {16'h0, rshift[15:0]};
            end
            F3_W: begin
                be_o       = 4'b1111;
                misalign_o = |addr_lo_i;
                rdata_o    = rword_i;
            end
            default: begin
                be_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one load/store at a time, programmable wait states,
// single-cycle response strobe. Optional counters under DMEM_CTRL_STATS_EN.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_CTRL_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_loads,
    output logic [STAT_W-1:0] stat_stores,
    output logic [STAT_W-1:0] stat_errs
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;

    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     rword_q;

    logic [31:0]     offset;
    logic            in_range;
    logic            f3_bad;
    logic            req_legal;
    logic            is_idle;
    logic [2:0]      la_funct3;
    logic [1:0]      la_addr_lo;
    logic [3:0]      la_be;
    logic [31:0]     la_wword;
    logic [31:0]     la_rdata;
    logic            la_misalign;

    // Unsigned compare first so an address below the base cannot wrap into range.
    assign offset    = req_addr - BASE_ADDR;
    assign in_range  = (req_addr >= BASE_ADDR) && ((offset >> 2) < 32'(DEPTH_WORDS));
    assign f3_bad    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    assign req_legal = in_range && !f3_bad && !la_misalign;

    assign is_idle    = (state_q == IDLE);
    assign req_ready  = is_idle && !rst;
    assign la_funct3  = is_idle ? req_funct3 : funct3_q;
    assign la_addr_lo = is_idle ? req_addr[1:0] : addr_lo_q;

    // The live request is checked in IDLE; the held request is steered afterwards.
    dmem_lane_align u_align (
        .funct3_i   (la_funct3),
        .addr_lo_i  (la_addr_lo),
        .wdata_i    (wdata_q),
        .rword_i    (rword_q),
        .be_o       (la_be),
        .wword_o    (la_wword),
        .rdata_o    (la_rdata),
        .misalign_o (la_misalign)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    funct3_d  = req_funct3;
                    addr_lo_d = req_addr[1:0];
                    idx_d     = offset[AW+1:2];
                    wdata_d   = req_wdata;
                    if (req_legal) begin
                        state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ACCESS: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = we_q ? 32'h0 : la_rdata;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            idx_q       <= '0;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Read tracks the next index so the word is ready when ACCESS begins.
    always_ff @(posedge clk) begin
        rword_q <= mem[idx_d];
        if ((state_q == ACCESS) && we_q && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (la_be[b]) begin
                    mem[idx_q][8*b +: 8] <= la_wword[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef DMEM_CTRL_STATS_EN
    logic [STAT_W-1:0] loads_q, stores_q, errs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            loads_q  <= '0;
            stores_q <= '0;
            errs_q   <= '0;
        end else if (state_q == RESP) begin
            if (rsp_err_q) begin
                if (errs_q != '1) errs_q <= errs_q + STAT_W'(1);
            end else if (we_q) begin
                if (stores_q != '1) stores_q <= stores_q + STAT_W'(1);
            end else begin
                if (loads_q != '1) loads_q <= loads_q + STAT_W'(1);
            end
        end
    end

    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_errs   = errs_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (BASE 0x10010000, 1024 words, 2 wait states).
// Covers lane steering, error paths, throughput under held req_valid and reset mid-operation.
module tb_dmem_ctrl;

    localparam logic [31:0] BASE  = 32'h10010000;
    localparam int          DEPTH = 1024;
    localparam int          WAITC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_CTRL_STATS_EN
    logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

    int checks   = 0;
    int failures = 0;

    dmem_ctrl #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
`ifdef DMEM_CTRL_STATS_EN
        ,
        .stat_loads  (stat_loads),
        .stat_stores (stat_stores),
        .stat_errs   (stat_errs)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Present a request from a negedge and hold it until the accepting posedge.
    task automatic accept(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        req_valid  = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check({tag, ".ready_timeout"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input logic exp_err, input logic [31:0] exp_rdata,
                          input string tag);
        int lat;
        lat = 0;
        accept(we, addr, wdata, f3, tag);
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        check({tag, ".lat"}, 32'(lat), exp_err ? 32'd1 : 32'(WAITC + 2));
        check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, ".rdata"}, rsp_rdata, exp_rdata);
        $display("txn %-12s we=%0d addr=%08h wdata=%08h f3=%03b -> rdata=%08h err=%0d lat=%0d",
                 tag, we, addr, wdata, f3, rsp_rdata, rsp_err, lat);
        @(negedge clk);
        check({tag, ".one_shot"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] exp_q[$];
        int          ready_cnt, rsp_cnt, last_ready, saw;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'b010;
        repeat (3) @(negedge clk);
        check("rst.ready", 32'(req_ready), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rdata", rsp_rdata, 32'h0);
        check("rst.err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst.ready", 32'(req_ready), 32'd1);

        // Basic word traffic and lane steering
        do_req(1'b1, BASE + 32'h10, 32'hDEADBEEF, 3'b010, 1'b0, 32'h0,        "sw_10");
        do_req(1'b0, BASE + 32'h10, 32'h0,        3'b010, 1'b0, 32'hDEADBEEF, "lw_10");
        do_req(1'b1, BASE + 32'h11, 32'h0000005A, 3'b000, 1'b0, 32'h0,        "sb_11");
        do_req(1'b0, BASE + 32'h10, 32'h0,        3'b010, 1'b0, 32'hDEAD5AEF, "lw_10b");
        do_req(1'b0, BASE + 32'h13, 32'h0,        3'b000, 1'b0, 32'hFFFFFFDE, "lb_13");
        do_req(1'b0, BASE + 32'h13, 32'h0,        3'b100, 1'b0, 32'h000000DE, "lbu_13");
        do_req(1'b0, BASE + 32'h12, 32'h0,        3'b101, 1'b0, 32'h0000DEAD, "lhu_12");
        do_req(1'b0, BASE + 32'h12, 32'h0,        3'b001, 1'b0, 32'hFFFFDEAD, "lh_12");
        do_req(1'b0, BASE + 32'h10, 32'h0,        3'b001, 1'b0, 32'h00005AEF, "lh_10");
        do_req(1'b0, BASE + 32'h11, 32'h0,        3'b000, 1'b0, 32'h0000005A, "lb_11");
        do_req(1'b1, BASE + 32'h14, 32'h00000000, 3'b010, 1'b0, 32'h0,        "sw_14");
        do_req(1'b1, BASE + 32'h16, 32'hABCD1234, 3'b001, 1'b0, 32'h0,        "sh_16");
        do_req(1'b0, BASE + 32'h14, 32'h0,        3'b010, 1'b0, 32'h12340000, "lw_14");

        // Boundary words and error paths
        do_req(1'b1, BASE,          32'h01234567, 3'b010, 1'b0, 32'h0,        "sw_0");
        do_req(1'b1, BASE + 32'hFFC, 32'hCAFEF00D, 3'b010, 1'b0, 32'h0,       "sw_last");
        do_req(1'b0, BASE + 32'hFFC, 32'h0,       3'b010, 1'b0, 32'hCAFEF00D, "lw_last");
        do_req(1'b0, BASE + 32'h2,  32'h0,        3'b010, 1'b1, 32'h0,        "lw_mis");
        do_req(1'b1, BASE + 32'h1,  32'h0000FFFF, 3'b001, 1'b1, 32'h0,        "sh_mis");
        do_req(1'b1, BASE + 32'h12, 32'h00000000, 3'b010, 1'b1, 32'h0,        "sw_mis");
        do_req(1'b0, BASE + 32'h1000, 32'h0,      3'b010, 1'b1, 32'h0,        "lw_oor");
        do_req(1'b1, BASE + 32'h1000, 32'hFFFFFFFF, 3'b010, 1'b1, 32'h0,      "sw_oor");
        do_req(1'b0, BASE - 32'h4,  32'h0,        3'b010, 1'b1, 32'h0,        "lw_below");
        do_req(1'b1, BASE - 32'h4,  32'hFFFFFFFF, 3'b010, 1'b1, 32'h0,        "sw_below");
        do_req(1'b1, BASE + 32'h10, 32'h00000000, 3'b011, 1'b1, 32'h0,        "f3_011");
        do_req(1'b0, BASE,          32'h0,        3'b010, 1'b0, 32'h01234567, "lw_0_chk");
        do_req(1'b0, BASE + 32'h10, 32'h0,        3'b010, 1'b0, 32'hDEAD5AEF, "lw_10_chk");
        do_req(1'b0, BASE + 32'hFFC, 32'h0,       3'b010, 1'b0, 32'hCAFEF00D, "lw_last_chk");

        // Throughput with req_valid held high and a new address every cycle
        for (int i = 0; i < 8; i++)
            do_req(1'b1, BASE + 32'h20 + 32'(4*i), 32'hA0000000 + 32'(i), 3'b010, 1'b0, 32'h0, "sw_tp");
        ready_cnt = 0; rsp_cnt = 0; last_ready = -1;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                rsp_cnt++;
                if (exp_q.size() > 0) check("tp.rdata", rsp_rdata, exp_q.pop_front());
                else check("tp.extra_rsp", 32'(rsp_cnt), 32'(ready_cnt));
            end
            if (c < 20) begin
                req_valid  = 1'b1;
                req_we     = 1'b0;
                req_funct3 = 3'b010;
                req_addr   = BASE + 32'h20 + 32'(4 * (c % 8));
                #1;
                if (req_ready) begin
                    if (last_ready >= 0) check("tp.gap", 32'(c - last_ready), 32'(WAITC + 3));
                    last_ready = c;
                    ready_cnt++;
                    exp_q.push_back(32'hA0000000 + 32'(c % 8));
                end
            end else begin
                req_valid = 1'b0;
            end
        end
        $display("txn throughput     readies=%0d responses=%0d", ready_cnt, rsp_cnt);
        check("tp.readies", 32'(ready_cnt), 32'd4);
        check("tp.responses", 32'(rsp_cnt), 32'd4);

        // Reset while a store waits: nothing commits, no response
        accept(1'b1, BASE + 32'h10, 32'h11111111, 3'b010, "sw_rst_wait");
        rst = 1'b1;
        @(negedge clk);
        check("rstwait.ready_in_rst", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        saw = 0;
        @(negedge clk);
        check("rstwait.ready_after", 32'(req_ready), 32'd1);
        repeat (6) begin
            if (rsp_valid) saw = 1;
            @(negedge clk);
        end
        check("rstwait.no_rsp", 32'(saw), 32'd0);
        $display("txn sw_rst_wait    aborted in WAIT");
        do_req(1'b0, BASE + 32'h10, 32'h0, 3'b010, 1'b0, 32'hDEAD5AEF, "lw_after_rw");

        // Reset coinciding with the ACCESS edge wins over the store
        accept(1'b1, BASE + 32'h10, 32'h22222222, 3'b010, "sw_rst_acc");
        repeat (WAITC) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        saw = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) saw = 1;
        end
        check("rstacc.no_rsp", 32'(saw), 32'd0);
        $display("txn sw_rst_acc     aborted on ACCESS edge");
        do_req(1'b0, BASE + 32'h10, 32'h0, 3'b010, 1'b0, 32'hDEAD5AEF, "lw_after_ra");

`ifdef DMEM_CTRL_STATS_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("stats.clr_loads", 32'(stat_loads), 32'd0);
        check("stats.clr_stores", 32'(stat_stores), 32'd0);
        check("stats.clr_errs", 32'(stat_errs), 32'd0);
        do_req(1'b0, BASE + 32'h10, 32'h0, 3'b010, 1'b0, 32'hDEAD5AEF, "st_lw1");
        do_req(1'b0, BASE,          32'h0, 3'b010, 1'b0, 32'h01234567, "st_lw2");
        do_req(1'b0, BASE + 32'h13, 32'h0, 3'b100, 1'b0, 32'h000000DE, "st_lbu");
        do_req(1'b1, BASE + 32'h40, 32'h5, 3'b010, 1'b0, 32'h0,        "st_sw1");
        do_req(1'b1, BASE + 32'h44, 32'h6, 3'b010, 1'b0, 32'h0,        "st_sw2");
        do_req(1'b0, BASE + 32'h41, 32'h0, 3'b010, 1'b1, 32'h0,        "st_mis");
        check("stats.loads", 32'(stat_loads), 32'd3);
        check("stats.stores", 32'(stat_stores), 32'd2);
        check("stats.errs", 32'(stat_errs), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("stats.rst_loads", 32'(stat_loads), 32'd0);
        check("stats.rst_stores", 32'(stat_stores), 32'd0);
        check("stats.rst_errs", 32'(stat_errs), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
